// File: rtl/push_button.sv
// Push-button conditioner: 2-flop sync, tick divider, shift debouncer,
// Moore edge detector emitting one clk-wide pulse per clean press.
module push_button #(
   parameter int DIV    = 250000,
   parameter int DB_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic z
);

   localparam int CW = $clog2(DIV) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic [1:0] {
      ZERO,
      EDGE,
      ONE
   } state_t;

   logic              x_s1;
   logic              x_s;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_d;
   logic              clkout;
   logic              clkout_d;
   logic              wrap;
   logic              tick;
   logic [DB_LEN-1:0] sh;
   logic [DB_LEN-1:0] sh_d;
   logic              db_level;
   logic              db_d;
   state_t            state;
   state_t            state_d;

   // tick marks the cycle just before clkout rises
   always_comb begin
      wrap     = (cnt == CNT_MAX);
      cnt_d    = wrap ? '0 : cnt + CW'(1);
      clkout_d = wrap ? ~clkout : clkout;
      tick     = wrap & ~clkout;
   end

   always_comb begin
      sh_d = sh;
      db_d = db_level;
      if (tick) begin
         sh_d = {sh[DB_LEN-2:0], x_s};
         if (&sh_d) begin
            db_d = 1'b1;
         end else if (~|sh_d) begin
            db_d = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ZERO: if (db_level) state_d = EDGE;
         EDGE: state_d = db_level ? ONE : ZERO;
         ONE:  if (!db_level) state_d = ZERO;
         default: state_d = ZERO;
      endcase
   end

   assign z = (state == EDGE);

   always_ff @(posedge clk) begin
      if (rst) begin
         x_s1     <= 1'b0;
         x_s      <= 1'b0;
         cnt      <= '0;
         clkout   <= 1'b0;
         sh       <= '0;
         db_level <= 1'b0;
         state    <= ZERO;
      end else begin
         x_s1     <= x;
         x_s      <= x_s1;
         cnt      <= cnt_d;
         clkout   <= clkout_d;
         sh       <= sh_d;
         db_level <= db_d;
         state    <= state_d;
      end
   end

endmodule

// File: tb/tb_push_button.sv
// Bench for push_button: vector table on a DIV=1 instance plus
// hand sequences on DIV=1, DIV=2 and DIV=4 instances.
module tb_push_button;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic x1 = 1'b0;
   logic x2 = 1'b0;
   logic x4 = 1'b0;
   logic z1;
   logic z2;
   logic z4;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   push_button #(.DIV(1), .DB_LEN(3)) u1 (
      .clk(clk), .rst(rst), .x(x1), .z(z1)
   );
   push_button #(.DIV(2), .DB_LEN(3)) u2 (
      .clk(clk), .rst(rst), .x(x2), .z(z2)
   );
   push_button #(.DIV(4), .DB_LEN(3)) u4 (
      .clk(clk), .rst(rst), .x(x4), .z(z4)
   );

   typedef struct {
      logic rst;
      logic x;
      logic z;
      logic db;
      logic ck;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic xv, input logic zv,
                      input logic dv, input logic cv);
      vec_t v;
      v.rst = r;
      v.x   = xv;
      v.z   = zv;
      v.db  = dv;
      v.ck  = cv;
      tv.push_back(v);
   endtask

   // drive away from the active edge, sample 1 ns after it
   task automatic cyc(input logic r, input logic a, input logic b,
                      input logic c);
      @(negedge clk);
      rst = r;
      x1  = a;
      x2  = b;
      x4  = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nz;
      int nrise;
      int lat;
      int anydb;
      logic zp;

      // idle after reset: clkout toggles every clk, first tick on edge 1
      add(1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0);
      for (int k = 1; k <= 50; k++) add(0, 0, 0, 0, k[0]);
      // bounce at tick rate, phased so every sample reads 0
      add(1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0);
      for (int k = 1; k <= 20; k++) add(0, ~k[0], 0, 0, k[0]);
      for (int k = 21; k <= 30; k++) add(0, 0, 0, 0, k[0]);
      // clean press: db up on edge 7, z on edge 8, db down on edge 27
      add(1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0);
      for (int k = 1; k <= 40; k++)
         add(0, k <= 20, k == 8, k >= 7 && k <= 26, k[0]);

      foreach (tv[i]) begin
         cyc(tv[i].rst, tv[i].x, 1'b0, 1'b0);
         chk($sformatf("vec%0d_z", i), z1, tv[i].z);
         chk($sformatf("vec%0d_db", i), u1.db_level, tv[i].db);
         chk($sformatf("vec%0d_clkout", i), u1.clkout, tv[i].ck);
      end

      // reset mid-hold: press is seen afresh after reset
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(0, 1, 0, 0);
         chk($sformatf("hold1_z%0d", k), z1, k == 8);
      end
      cyc(1, 1, 0, 0);
      chk("rstmid_z", z1, 0);
      for (int k = 1; k <= 40; k++) begin
         cyc(0, 1, 0, 0);
         chk($sformatf("hold2_z%0d", k), z1, k == 8);
      end

      // long hold on DIV=4, released and pressed again
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      nz = 0;
      nrise = 0;
      lat = 0;
      zp = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         cyc(0, 0, 0, 1);
         if (z4) nz++;
         if (z4 && !zp) nrise++;
         if (z4 && lat == 0) lat = k;
         zp = z4;
      end
      chk("hold4_high_cycles", nz, 1);
      chk("hold4_pulses", nrise, 1);
      chk("hold4_latency_ok", (lat > 0 && lat <= 35) ? 1 : 0, 1);
      nz = 0;
      for (int k = 1; k <= 100; k++) begin
         cyc(0, 0, 0, 0);
         if (z4) nz++;
      end
      chk("release4_z", nz, 0);
      chk("release4_db", u4.db_level, 0);
      nz = 0;
      nrise = 0;
      zp = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         cyc(0, 0, 0, 1);
         if (z4) nz++;
         if (z4 && !zp) nrise++;
         zp = z4;
      end
      chk("press2_high_cycles", nz, 1);
      chk("press2_pulses", nrise, 1);

      // short glitches on DIV=2: 3 clk high is under one tick period
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      nz = 0;
      anydb = 0;
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 23; k++) begin
            cyc(0, 0, k < 3, 0);
            if (z2) nz++;
            if (u2.db_level) anydb = 1;
         end
      end
      chk("glitch2_z", nz, 0);
      chk("glitch2_db", anydb, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
